// File: rtl/fifo_wr_arb.sv
// Purpose : burst-fair round-robin arbiter sharing one FIFO write port among NUM_REQ writers.
// Latency : combinational grant (same cycle as req); arbitration state updates on the next rising edge.
// Backpres: full=1 suppresses every grant and freezes state, pointer and burst count.
//
// Ports: clk/rst_n (async active-low); req/req_data from writers; gnt back to writers;
//        write/write_data to the FIFO; full from the FIFO; owner_id/busy expose burst state.
module fifo_wr_arb #(
    parameter int NUM_REQ         = 4,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int BURST_LEN       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic                               write,
    output logic [FIFO_DATA_WIDTH-1:0]         write_data,
    input  logic                               full,
    output logic [2:0]                         owner_id,
    output logic                               busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0] state;
    logic [2:0] owner;
    logic [2:0] ptr;
    logic [3:0] cnt;

    logic       grant_vld;
    logic [2:0] grant_idx;

    function automatic logic [2:0] next_idx(input logic [2:0] k);
        return (k == 3'(NUM_REQ - 1)) ? 3'd0 : k + 3'd1;
    endfunction

    // Grant selection. Outputs are gated by rst_n so an asserted reset clears
    // them immediately, not only once the registers have been cleared.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 3'd0;
        if (rst_n && !full) begin
            if (state == ST_OWN) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner == 3'(i) && req[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = 3'(i);
                    end
                end
            end else begin
                // Scan offsets from far to near so the nearest requester at or
                // after the pointer wins (last assignment takes priority).
                for (int off = NUM_REQ - 1; off >= 0; off--) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req[i] && (int'(ptr) + off) % NUM_REQ == i) begin
                            grant_vld = 1'b1;
                            grant_idx = 3'(i);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        gnt        = '0;
        write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == 3'(i)) begin
                gnt[i]     = 1'b1;
                write_data = req_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    assign write    = grant_vld;
    assign busy     = rst_n && (state == ST_OWN);
    assign owner_id = busy ? owner : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
        end else if (!full) begin
            if (state == ST_IDLE) begin
                if (grant_vld) begin
                    if (BURST_LEN == 1) begin
                        ptr <= next_idx(grant_idx);
                    end else begin
                        state <= ST_OWN;
                        owner <= grant_idx;
                        cnt   <= 4'd1;
                    end
                end
            end else begin
                if (grant_vld && (cnt + 4'd1) != 4'(BURST_LEN)) begin
                    cnt <= cnt + 4'd1;
                end else begin
                    // Burst complete, or owner dropped req (one-cycle bubble):
                    // release the port and move the pointer past the owner.
                    state <= ST_IDLE;
                    ptr   <= next_idx(owner);
                    cnt   <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: two instances (burst 4 and burst 1) share stimulus and
// are compared every cycle against a queue/arithmetic reference model.
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;

    logic [3:0]  gnt_o  [2];
    logic        wr_o   [2];
    logic [7:0]  wd_o   [2];
    logic [2:0]  oid_o  [2];
    logic        busy_o [2];

    always #5 clk = ~clk;

    fifo_wr_arb #(.NUM_REQ(4), .FIFO_DATA_WIDTH(8), .BURST_LEN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt_o[0]), .write(wr_o[0]), .write_data(wd_o[0]), .full(full),
        .owner_id(oid_o[0]), .busy(busy_o[0])
    );

    fifo_wr_arb #(.NUM_REQ(4), .FIFO_DATA_WIDTH(8), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt_o[1]), .write(wr_o[1]), .write_data(wd_o[1]), .full(full),
        .owner_id(oid_o[1]), .busy(busy_o[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: owner = -1 means no burst in progress.
    int bl      [2] = '{4, 1};
    int m_owner [2];
    int m_cnt   [2];
    int m_ptr   [2];
    logic [7:0] wd_seen [2];

    bit   fifo_mode = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_cnt[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    function automatic int model_gnt(input int d);
        if (!rst_n || full) return -1;
        if (m_owner[d] >= 0) return req[m_owner[d]] ? m_owner[d] : -1;
        for (int o = 0; o < 4; o++)
            if (req[(m_ptr[d] + o) % 4]) return (m_ptr[d] + o) % 4;
        return -1;
    endfunction

    task automatic model_step(input int d, input int g);
        if (!rst_n) begin
            m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0;
        end else if (!full) begin
            if (m_owner[d] >= 0) begin
                if (g >= 0 && m_cnt[d] + 1 < bl[d]) begin
                    m_cnt[d]++;
                end else begin
                    m_ptr[d]   = (m_owner[d] + 1) % 4;
                    m_owner[d] = -1;
                    m_cnt[d]   = 0;
                end
            end else if (g >= 0) begin
                if (bl[d] == 1) m_ptr[d] = (g + 1) % 4;
                else begin m_owner[d] = g; m_cnt[d] = 1; end
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle, then
    // advances one clock and updates the model.
    task automatic cycle(input string tag);
        int ge [2];
        #3;
        for (int d = 0; d < 2; d++) begin
            ge[d] = model_gnt(d);
            wd_seen[d] = wd_o[d];
            chk($sformatf("%s_gnt%0d", tag, d), 32'(gnt_o[d]), (ge[d] >= 0) ? (32'd1 << ge[d]) : 32'd0);
            chk($sformatf("%s_wr%0d", tag, d), 32'(wr_o[d]), 32'(ge[d] >= 0));
            chk($sformatf("%s_wd%0d", tag, d), 32'(wd_o[d]), (ge[d] >= 0) ? 32'((req_data >> (8 * ge[d])) & 32'hff) : 32'd0);
            chk($sformatf("%s_busy%0d", tag, d), 32'(busy_o[d]), 32'(m_owner[d] >= 0));
            chk($sformatf("%s_oid%0d", tag, d), 32'(oid_o[d]), (m_owner[d] >= 0) ? 32'(m_owner[d]) : 32'd0);
        end
        if (fifo_mode) begin
            chk("fifo_wr_while_full", 32'(wr_o[0] & full), 32'd0);
            if (wr_o[0]) fifo_q.push_back(wd_o[0]);
            if (ge[0] >= 0) exp_q.push_back(req_data[8*ge[0] +: 8]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d, ge[d]);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        full  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] seq31 [5];
        seq31 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        // Reset asserted with all requests pending: outputs must be forced low.
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_data = 32'h44332211;
        full     = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_gnt%0d", d), 32'(gnt_o[d]), 32'd0);
            chk($sformatf("rst_wr%0d", d), 32'(wr_o[d]), 32'd0);
            chk($sformatf("rst_wd%0d", d), 32'(wd_o[d]), 32'd0);
            chk($sformatf("rst_busy%0d", d), 32'(busy_o[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, burst of 4 on instance 0.
        req = 4'b0001; req_data = 32'h00000011;
        for (int i = 0; i < 6; i++) cycle("solo");

        // All requesting, burst-1 instance rotates 11,22,33,44,11.
        do_reset();
        req = 4'b1111; req_data = 32'h44332211;
        for (int i = 0; i < 5; i++) begin
            cycle("rr");
            chk($sformatf("rr_seq%0d", i), 32'(wd_seen[1]), 32'(seq31[i]));
        end

        // Owner 2 stalled by full mid-burst.
        do_reset();
        req = 4'b0100; req_data = 32'h00C30000;
        cycle("own2"); cycle("own2");
        full = 1'b1;
        for (int i = 0; i < 3; i++) cycle("own2_full");
        full = 1'b0;
        for (int i = 0; i < 3; i++) cycle("own2_resume");

        // Owner 1 drops request after two writes while requester 3 waits.
        do_reset();
        req = 4'b1010; req_data = 32'hD3000B00;
        cycle("drop"); cycle("drop");
        req = 4'b1000;
        cycle("drop_bubble"); cycle("drop_next"); cycle("drop_next");

        // Asynchronous reset mid-burst by owner 3.
        do_reset();
        req = 4'b1000; req_data = 32'hE3000000;
        cycle("a3"); cycle("a3");
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt_o[0]), 32'd0);
        chk("arst_wr", 32'(wr_o[0]), 32'd0);
        chk("arst_busy", 32'(busy_o[0]), 32'd0);
        chk("arst_oid", 32'(oid_o[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b1001; req_data = 32'hA00000B0;
        cycle("rearb");
        chk("rearb_first0", 32'(wd_seen[0]), 32'hB0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req      = 4'($urandom);
            req_data = $urandom;
            full     = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end

        // Behavioural 8-deep FIFO: fill without reads, then drain and compare order.
        do_reset();
        fifo_mode = 1;
        for (int i = 0; i < 40; i++) begin
            req      = 4'($urandom);
            req_data = $urandom;
            full     = (fifo_q.size() >= 8);
            cycle("fifo");
        end
        fifo_mode = 0;
        chk("fifo_depth", 32'(fifo_q.size()), 32'(exp_q.size()));
        while (fifo_q.size() > 0 && exp_q.size() > 0)
            chk("fifo_order", 32'(fifo_q.pop_front()), 32'(exp_q.pop_front()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
